mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 8-bit 8-to-1 multiplexer datapath among eight requesters. It owns the 3-bit select, grants one requester at a time for a burst of beats, and presents the selected byte downstream with a valid/ready handshake. It sits directly in front of the byte mux and drives its select.

---
 rtl/mux8_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// Round-robin arbiter that owns the select of an 8-to-1 byte mux. It grants one
// requester at a time for a burst of beats. It presents the selected byte
// downstream with a valid/ready handshake. A grant is released on an accepted
// last beat, on reaching MAX_BEATS beats, or when the grantee drops its request.
module mux8_rr_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic [7:0] I0,
    input  logic [7:0] I1,
    input  logic [7:0] I2,
    input  logic [7:0] I3,
    input  logic [7:0] I4,
    input  logic [7:0] I5,
    input  logic [7:0] I6,
    input  logic [7:0] I7,
    input  logic       o_ready,
    output logic [7:0] o,
    output logic       o_valid,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       busy
);

    localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       s_q, s_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       accept;

    // Search ptr+1, ptr+2, ... (wrapping) for the first active request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Byte mux driven by the registered select; valid only while the grantee still requests.
    always_comb begin
        case (s_q)
            3'd0:    o = I0;
            3'd1:    o = I1;
            3'd2:    o = I2;
            3'd3:    o = I3;
            3'd4:    o = I4;
            3'd5:    o = I5;
            3'd6:    o = I6;
            default: o = I7;
        endcase
        o_valid = (state_q == BUSY) && req[s_q];
    end

    assign accept = o_valid && o_ready;

    // Next-state logic: grant in IDLE, count beats and decide release in BUSY.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    s_d     = win_idx;
                    gnt_d   = 8'd1 << win_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req[s_q] || (accept && (last[s_q] || cnt_q == CNT_LAST))) begin
                    gnt_d   = 8'd0;
                    ptr_d   = s_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and grant registers; ptr resets to 7 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            s_q     <= 3'd0;
            ptr_q   <= 3'd7;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign s    = s_q;
    assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of the round-robin burst arbiter.
module tb_mux8_rr_arbiter;

    localparam int MB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] last;
    logic [7:0] data [8];
    logic       o_ready;
    logic [7:0] o;
    logic       o_valid;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;

    int tests_run;
    int tests_failed;

    // Behavioural model state.
    bit m_busy;
    int m_s;
    int m_ptr;
    int m_beats;

    mux8_rr_arbiter #(.MAX_BEATS(MB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .I0      (data[0]),
        .I1      (data[1]),
        .I2      (data[2]),
        .I3      (data[3]),
        .I4      (data[4]),
        .I5      (data[5]),
        .I6      (data[6]),
        .I7      (data[7]),
        .o_ready (o_ready),
        .o       (o),
        .o_valid (o_valid),
        .gnt     (gnt),
        .s       (s),
        .busy    (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_s     = 0;
        m_ptr   = 7;
        m_beats = 0;
    endtask

    // Round-robin pick: first requester after ptr, wrapping modulo 8.
    function automatic int rr_pick(input int ptr, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int w;
        if (!m_busy) begin
            w = rr_pick(m_ptr, req);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_s     = w;
                m_beats = 0;
            end
        end else if (!req[m_s]) begin
            m_busy = 1'b0;
            m_ptr  = m_s;
        end else if (o_ready) begin
            m_beats++;
            if (last[m_s] || m_beats == MB) begin
                m_busy  = 1'b0;
                m_ptr   = m_s;
                m_beats = 0;
            end
        end
    endtask

    task automatic check_comb(input string tag);
        check_output({tag, ".o_valid"}, {7'd0, o_valid}, {7'd0, m_busy && req[m_s]});
        check_output({tag, ".o"}, o, data[m_s]);
    endtask

    task automatic check_regs(input string tag);
        check_output({tag, ".gnt"}, gnt, m_busy ? (8'd1 << m_s) : 8'd0);
        check_output({tag, ".s"}, {5'd0, s}, 8'(m_s));
        check_output({tag, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
    endtask

    // One cycle: drive inputs, check combinational outputs, clock, check registers.
    task automatic apply_stimulus(input string tag, input logic [7:0] r, input logic [7:0] l, input logic rdy);
        req     = r;
        last    = l;
        o_ready = rdy;
        #2;
        check_comb(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 8; i++) data[i] = 8'(i * 8'h11);
        req     = 8'd0;
        last    = 8'd0;
        o_ready = 1'b0;
        rst_n   = 1'b1;
        model_reset();

        // Reset values.
        #3 rst_n = 1'b0;
        #1;
        check_regs("reset");
        check_comb("reset");
        check_output("reset.o_is_I0", o, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request to requester 3, last on the third beat.
        apply_stimulus("single.grant", 8'h08, 8'h00, 1'b1);
        check_output("single.gnt08", gnt, 8'h08);
        apply_stimulus("single.beat1", 8'h08, 8'h00, 1'b1);
        check_output("single.o33", o, 8'h33);
        apply_stimulus("single.beat2", 8'h08, 8'h00, 1'b1);
        apply_stimulus("single.beat3", 8'h08, 8'h08, 1'b1);
        check_output("single.released", {7'd0, busy}, 8'h00);
        apply_stimulus("single.idle", 8'h00, 8'h00, 1'b1);

        // Fairness: all requesting, one-beat bursts.
        for (int i = 0; i < 18; i++) apply_stimulus("fair", 8'hFF, 8'hFF, 1'b1);
        apply_stimulus("fair.drain", 8'h00, 8'h00, 1'b1);

        // Wrap and skip: leave ptr at 6, then 0 wins before 5.
        apply_stimulus("wrap.g6", 8'h40, 8'hFF, 1'b1);
        apply_stimulus("wrap.r6", 8'h40, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus("wrap", 8'h21, 8'hFF, 1'b1);
        apply_stimulus("wrap.drain", 8'h00, 8'h00, 1'b1);

        // Forced release after MB beats with last never set.
        for (int i = 0; i < MB + 3; i++) apply_stimulus("forced", 8'h04, 8'h00, 1'b1);
        apply_stimulus("forced.drain", 8'h00, 8'h00, 1'b1);

        // Backpressure then abandon on requester 4.
        apply_stimulus("bp.grant", 8'h10, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus("bp.stall", 8'h10, 8'h10, 1'b0);
        apply_stimulus("bp.abandon", 8'h00, 8'h00, 1'b1);
        apply_stimulus("bp.idle", 8'h00, 8'h00, 1'b1);

        // Reset mid-burst on requester 6.
        apply_stimulus("mid.grant", 8'h40, 8'h00, 1'b1);
        apply_stimulus("mid.beat1", 8'h40, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_output("mid.gnt", gnt, 8'h00);
        check_output("mid.o_valid", {7'd0, o_valid}, 8'h00);
        check_regs("mid.reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("mid.regrant", 8'h41, 8'h00, 1'b1);
        check_output("mid.s0", {5'd0, s}, 8'h00);
        apply_stimulus("mid.drop", 8'h00, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 8; j++) data[j] = 8'($urandom);
            apply_stimulus("rand", 8'($urandom) & 8'($urandom), 8'($urandom_range(0, 255)) & 8'($urandom),
                           1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
